// File: rtl/wb_pwm_multichan.sv
// Wishbone slave driving NUM_CH PWM outputs from one shared prescaler and period counter.
// Period and duty registers are double-buffered. The active copies reload on every period wrap.
module wb_pwm_multichan #(
    parameter int          NUM_CH             = 8,
    parameter int          CNT_WIDTH          = 16,
    parameter int          PRESC_WIDTH        = 16,
    parameter int          APERSIZE           = 10,
    parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC
) (
    input  logic              WBs_CLK_i,
    input  logic              WBs_RST_i,
    input  logic [16:0]       WBs_ADR_i,
    input  logic              WBs_CYC_i,
    input  logic              WBs_STB_i,
    input  logic              WBs_WE_i,
    input  logic [3:0]        WBs_BYTE_STB_i,
    input  logic [31:0]       WBs_DAT_i,
    output logic [31:0]       WBs_DAT_o,
    output logic              WBs_ACK_o,
    output logic [NUM_CH-1:0] PWM_o,
    output logic              PWM_IRQ_o
);

    typedef logic [CNT_WIDTH-1:0]   cnt_t;
    typedef logic [PRESC_WIDTH-1:0] presc_t;
    typedef logic [NUM_CH-1:0]      ch_t;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_PRESC  = 32'h01;
    localparam logic [31:0] A_PERIOD = 32'h02;
    localparam logic [31:0] A_STATUS = 32'h03;
    localparam logic [31:0] A_CH_EN  = 32'h04;
    localparam logic [31:0] A_CH_POL = 32'h05;
    localparam logic [31:0] A_DUTY   = 32'h40;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wdat,
                                                input logic [3:0] sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) res[8*b +: 8] = sel[b] ? wdat[8*b +: 8] : old[8*b +: 8];
        return res;
    endfunction

    function automatic logic [31:0] zext_cnt(input cnt_t v);
        logic [31:0] res;
        res = '0;
        res[CNT_WIDTH-1:0] = v;
        return res;
    endfunction

    function automatic logic [31:0] zext_presc(input presc_t v);
        logic [31:0] res;
        res = '0;
        res[PRESC_WIDTH-1:0] = v;
        return res;
    endfunction

    function automatic logic [31:0] zext_ch(input ch_t v);
        logic [31:0] res;
        res = '0;
        res[NUM_CH-1:0] = v;
        return res;
    endfunction

    // Reset asserts asynchronously. Its release is delayed through two flops so it is clean in this domain.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_i) begin
        if (!WBs_RST_i) rst_sync_q <= 2'b00;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic [1:0]  ctrl_q, ctrl_d;
    presc_t      presc_q, presc_d, pcnt_q, pcnt_d;
    cnt_t        period_sh_q, period_sh_d, period_act_q, period_act_d, cnt_q, cnt_d;
    cnt_t        duty_sh_q [NUM_CH];
    cnt_t        duty_sh_d [NUM_CH];
    cnt_t        duty_act_q[NUM_CH];
    cnt_t        duty_act_d[NUM_CH];
    logic        wrap_q, wrap_d, ack_q, ack_d;
    ch_t         ch_en_q, ch_en_d, ch_pol_q, ch_pol_d, pwm_q, pwm_d;
    logic [31:0] dat_q, dat_d;

    logic        acc, wr, en, tick, wrap_evt, w1c;
    logic [31:0] widx, rdata;
    logic        unused_adr;

    assign unused_adr = ^WBs_ADR_i;

    always_comb begin
        ctrl_d       = ctrl_q;
        presc_d      = presc_q;
        pcnt_d       = pcnt_q;
        period_sh_d  = period_sh_q;
        period_act_d = period_act_q;
        cnt_d        = cnt_q;
        ch_en_d      = ch_en_q;
        ch_pol_d     = ch_pol_q;
        for (int n = 0; n < NUM_CH; n++) begin
            duty_sh_d[n]  = duty_sh_q[n];
            duty_act_d[n] = duty_act_q[n];
        end

        // The ack is only ever one cycle long. Writes commit on the edge that closes the ack cycle.
        acc   = WBs_CYC_i & WBs_STB_i;
        ack_d = acc & ~ack_q;
        wr    = acc & WBs_WE_i & ack_q;
        widx  = '0;
        widx[APERSIZE-3:0] = WBs_ADR_i[APERSIZE-1:2];

        rdata = DEFAULT_READ_VALUE;
        case (widx)
            A_CTRL:   rdata = {30'b0, ctrl_q};
            A_PRESC:  rdata = zext_presc(presc_q);
            A_PERIOD: rdata = zext_cnt(period_sh_q);
            A_STATUS: rdata = {31'b0, wrap_q};
            A_CH_EN:  rdata = zext_ch(ch_en_q);
            A_CH_POL: rdata = zext_ch(ch_pol_q);
            default:  ;
        endcase
        for (int n = 0; n < NUM_CH; n++)
            if (widx == A_DUTY + 32'(n)) rdata = zext_cnt(duty_sh_q[n]);
        dat_d = ack_d ? rdata : 32'h0;

        en       = ctrl_q[0];
        tick     = en && (pcnt_q == presc_q);
        wrap_evt = tick && (cnt_q >= period_act_q);
        if (!en) begin
            pcnt_d       = '0;
            cnt_d        = '0;
            period_act_d = period_sh_q;
            for (int n = 0; n < NUM_CH; n++) duty_act_d[n] = duty_sh_q[n];
        end else if (tick) begin
            pcnt_d = '0;
            cnt_d  = wrap_evt ? '0 : cnt_q + cnt_t'(1);
            if (wrap_evt) begin
                period_act_d = period_sh_q;
                for (int n = 0; n < NUM_CH; n++) duty_act_d[n] = duty_sh_q[n];
            end
        end else begin
            pcnt_d = pcnt_q + presc_t'(1);
        end

        if (wr) begin
            case (widx)
                A_CTRL:   ctrl_d      = 2'(merge_bytes({30'b0, ctrl_q}, WBs_DAT_i, WBs_BYTE_STB_i));
                A_PRESC: begin
                    presc_d = presc_t'(merge_bytes(zext_presc(presc_q), WBs_DAT_i, WBs_BYTE_STB_i));
                    pcnt_d  = '0;
                end
                A_PERIOD: period_sh_d = cnt_t'(merge_bytes(zext_cnt(period_sh_q), WBs_DAT_i, WBs_BYTE_STB_i));
                A_CH_EN:  ch_en_d     = ch_t'(merge_bytes(zext_ch(ch_en_q), WBs_DAT_i, WBs_BYTE_STB_i));
                A_CH_POL: ch_pol_d    = ch_t'(merge_bytes(zext_ch(ch_pol_q), WBs_DAT_i, WBs_BYTE_STB_i));
                default:  ;
            endcase
            for (int n = 0; n < NUM_CH; n++)
                if (widx == A_DUTY + 32'(n))
                    duty_sh_d[n] = cnt_t'(merge_bytes(zext_cnt(duty_sh_q[n]), WBs_DAT_i, WBs_BYTE_STB_i));
        end

        // A new wrap takes priority over a simultaneous clear, so no event is lost.
        w1c    = wr && (widx == A_STATUS) && WBs_BYTE_STB_i[0] && WBs_DAT_i[0];
        wrap_d = wrap_evt | (wrap_q & ~w1c);

        for (int n = 0; n < NUM_CH; n++)
            pwm_d[n] = (en & ch_en_q[n] & (cnt_q < duty_act_q[n])) ^ ch_pol_q[n];
    end

    always_ff @(posedge WBs_CLK_i or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q       <= '0;
            presc_q      <= '0;
            pcnt_q       <= '0;
            period_sh_q  <= '0;
            period_act_q <= '0;
            cnt_q        <= '0;
            ch_en_q      <= '0;
            ch_pol_q     <= '0;
            wrap_q       <= 1'b0;
            ack_q        <= 1'b0;
            dat_q        <= '0;
            pwm_q        <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                duty_sh_q[n]  <= '0;
                duty_act_q[n] <= '0;
            end
        end else begin
            ctrl_q       <= ctrl_d;
            presc_q      <= presc_d;
            pcnt_q       <= pcnt_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            cnt_q        <= cnt_d;
            ch_en_q      <= ch_en_d;
            ch_pol_q     <= ch_pol_d;
            wrap_q       <= wrap_d;
            ack_q        <= ack_d;
            dat_q        <= dat_d;
            pwm_q        <= pwm_d;
            for (int n = 0; n < NUM_CH; n++) begin
                duty_sh_q[n]  <= duty_sh_d[n];
                duty_act_q[n] <= duty_act_d[n];
            end
        end
    end

    assign WBs_ACK_o = ack_q;
    assign WBs_DAT_o = dat_q;
    assign PWM_o     = pwm_q;
    assign PWM_IRQ_o = wrap_q & ctrl_q[1];

endmodule
